// File: rtl/logger_pkg.sv
// Shared width helpers for the multi-channel logger.
//   chan_w : bits needed for a channel id (at least 1)
//   mem_w  : stored word width, smallest power of two covering the packed
//            entry and the readback word
//   sec_w  : bits needed to select one readback word within a stored word
//   DROP_CNT_W : width of the saturating drop counter
package logger_pkg;

  localparam int DROP_CNT_W = 16;

  function automatic int chan_w(input int num_chan);
    return (num_chan > 1) ? $clog2(num_chan) : 1;
  endfunction

  function automatic int mem_w(input int entry_w, input int output_w);
    int w;
    w = 1;
    for (int i = 0; i < 31; i++) begin
      if (w < entry_w || w < output_w) w = w * 2;
    end
    return w;
  endfunction

  function automatic int sec_w(input int mem_w_v, input int output_w);
    return $clog2(mem_w_v / output_w);
  endfunction

endpackage

// File: rtl/ram_1r1w_sync_backpressure.sv
// One-write / one-read synchronous RAM with a one-deep registered read
// response that holds while the consumer is not ready. A read and a write to
// the same address in the same cycle return the old contents.
// Contents are never reset.
//   i_wr_en/i_wr_addr/i_wr_data        : write port
//   i_rd_req_val/o_rd_req_rdy/i_rd_addr : read request handshake
//   o_rd_resp_val/i_rd_resp_rdy/o_rd_resp_data : read response handshake
module ram_1r1w_sync_backpressure #(
  parameter int DATA_W = 128,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_rd_req_val,
  output logic              o_rd_req_rdy,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic              o_rd_resp_val,
  input  logic              i_rd_resp_rdy,
  output logic [DATA_W-1:0] o_rd_resp_data
);

  logic [DATA_W-1:0] r_mem [0:(1 << ADDR_W) - 1];
  logic              r_vld_p1;
  logic [DATA_W-1:0] r_data_p1;
  logic              w_rd_fire;

  assign o_rd_req_rdy = ~r_vld_p1 | i_rd_resp_rdy;
  assign w_rd_fire    = i_rd_req_val & o_rd_req_rdy;

  // ---- stage p0 -> p1: array access ----
  always_ff @(posedge clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
    if (w_rd_fire) r_data_p1 <= r_mem[i_rd_addr];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_p1 <= 1'b0;
    end else if (o_rd_req_rdy) begin
      r_vld_p1 <= i_rd_req_val;
    end
  end

  assign o_rd_resp_val  = r_vld_p1;
  assign o_rd_resp_data = r_data_p1;

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter, one-hot grant, at most one grant per cycle.
// Priority starts at the channel after the last one granted; after reset
// channel 0 has priority. Grant is forced low while rst is high.
//   clk, rst : clock, synchronous active-high reset
//   i_req    : per-channel request
//   o_grant  : one-hot grant (zero when nothing requests)
module rr_arbiter
  import logger_pkg::*;
#(
  parameter int NUM_CHAN = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_CHAN-1:0] i_req,
  output logic [NUM_CHAN-1:0] o_grant
);

  localparam int IDX_W = chan_w(NUM_CHAN);

  logic [IDX_W-1:0]    r_prio;
  logic [IDX_W-1:0]    w_idx;
  logic [IDX_W-1:0]    w_next;
  logic [NUM_CHAN-1:0] w_rot;
  logic [NUM_CHAN-1:0] w_grant;
  logic                w_found;

  always_comb begin
    // Rotate requests so the priority channel sits at bit 0.
    w_rot   = NUM_CHAN'({i_req, i_req} >> r_prio);
    w_found = 1'b0;
    w_idx   = r_prio;
    for (int k = 0; k < NUM_CHAN; k++) begin
      if (!w_found && w_rot[k]) begin
        w_found = 1'b1;
        w_idx   = (int'(r_prio) + k >= NUM_CHAN) ? IDX_W'(int'(r_prio) + k - NUM_CHAN)
                                                 : IDX_W'(int'(r_prio) + k);
      end
    end
    w_grant = '0;
    for (int j = 0; j < NUM_CHAN; j++) begin
      if (w_found && !rst && (IDX_W'(j) == w_idx)) w_grant[j] = 1'b1;
    end
    w_next = (int'(w_idx) == NUM_CHAN - 1) ? '0 : w_idx + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_prio <= '0;
    end else if (|w_grant) begin
      r_prio <= w_next;
    end
  end

  assign o_grant = w_grant;

endmodule

// File: rtl/multi_chan_logger.sv
// Multi-channel timestamped logger. A round-robin arbiter accepts at most one
// beat per cycle; stored beats are packed as {timestamp, chan_id, data, pad}
// (zero pad at the LSBs) into a RAM word. Readback returns one OUTPUT_W
// section of an entry, section 0 being the MSBs, two cycles after request.
//   clk, rst, clear          : clock, sync reset, sync pointer/counter clear
//   logging_active, wrap_mode: capture enable, circular (1) / stop-when-full (0)
//   in_val/in_data/in_rdy    : per-channel input handshake
//   rd_req_val/rd_req_addr   : read request {entry index, section index}
//   rd_resp_val/rd_resp_data : read response
//   wr_ptr, entry_cnt, full, has_looped, drop_cnt : status
module multi_chan_logger
  import logger_pkg::*;
#(
  parameter int NUM_CHAN       = 4,
  parameter int INPUT_W        = 96,
  parameter int TS_W           = 28,
  parameter int MEM_DEPTH_LOG2 = 8,
  parameter int OUTPUT_W       = 64,
  localparam int CHAN_W        = chan_w(NUM_CHAN),
  localparam int ENTRY_W       = TS_W + CHAN_W + INPUT_W,
  localparam int MEM_W         = mem_w(ENTRY_W, OUTPUT_W),
  localparam int SEC_W         = sec_w(MEM_W, OUTPUT_W),
  localparam int RA_W          = MEM_DEPTH_LOG2 + SEC_W
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clear,
  input  logic                        logging_active,
  input  logic                        wrap_mode,
  input  logic [NUM_CHAN-1:0]         in_val,
  input  logic [NUM_CHAN*INPUT_W-1:0] in_data,
  output logic [NUM_CHAN-1:0]         in_rdy,
  input  logic                        rd_req_val,
  input  logic [RA_W-1:0]             rd_req_addr,
  output logic                        rd_resp_val,
  output logic [OUTPUT_W-1:0]         rd_resp_data,
  output logic [MEM_DEPTH_LOG2-1:0]   wr_ptr,
  output logic [MEM_DEPTH_LOG2:0]     entry_cnt,
  output logic                        full,
  output logic                        has_looped,
  output logic [DROP_CNT_W-1:0]       drop_cnt
);

  localparam int NSEC   = MEM_W / OUTPUT_W;
  localparam int PAD_W  = MEM_W - ENTRY_W;
  localparam int SECI_W = (SEC_W > 0) ? SEC_W : 1;
  localparam logic [MEM_DEPTH_LOG2:0] FULL_CNT = {1'b1, {MEM_DEPTH_LOG2{1'b0}}};

  logic [TS_W-1:0]           r_ts;
  logic [MEM_DEPTH_LOG2-1:0] r_wr_ptr;
  logic [MEM_DEPTH_LOG2:0]   r_entry_cnt;
  logic                      r_has_looped;
  logic [DROP_CNT_W-1:0]     r_drop_cnt;

  logic [NUM_CHAN-1:0]       w_grant;
  logic [CHAN_W-1:0]         w_gid;
  logic [INPUT_W-1:0]        w_data;
  logic [MEM_W-1:0]          w_entry;
  logic                      w_full;
  logic                      w_xfer;
  logic                      w_block;
  logic                      w_store;
  logic                      w_drop;

  logic [MEM_DEPTH_LOG2-1:0] w_rd_entry;
  logic [SECI_W-1:0]         w_rd_sec;
  logic                      w_rd_req_rdy;
  logic                      w_rd_fire;
  logic [SECI_W-1:0]         r_sec_p1;
  logic                      w_ram_vld_p1;
  logic [MEM_W-1:0]          w_ram_data_p1;
  logic [OUTPUT_W-1:0]       w_sec_data;
  logic                      r_resp_vld_p2;
  logic [OUTPUT_W-1:0]       r_resp_data_p2;

  // Free-running timestamp; only rst touches it.
  always_ff @(posedge clk) begin
    if (rst) r_ts <= '0;
    else     r_ts <= r_ts + 1'b1;
  end

  rr_arbiter #(.NUM_CHAN(NUM_CHAN)) u_arb (
    .clk     (clk),
    .rst     (rst),
    .i_req   (in_val),
    .o_grant (w_grant)
  );

  always_comb begin
    w_gid  = '0;
    w_data = '0;
    for (int i = 0; i < NUM_CHAN; i++) begin
      if (w_grant[i]) begin
        w_gid  = CHAN_W'(i);
        w_data = in_data[i*INPUT_W +: INPUT_W];
      end
    end
  end

  assign w_entry = MEM_W'({r_ts, w_gid, w_data}) << PAD_W;
  assign w_full  = (r_entry_cnt == FULL_CNT);
  assign w_xfer  = |(in_val & w_grant);
  assign w_block = ~wrap_mode & w_full;
  // The winner is always handshaked; clear and sink conditions just discard it.
  assign w_store = w_xfer & logging_active & ~clear & ~w_block;
  assign w_drop  = w_xfer & logging_active & ~clear &  w_block;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_wr_ptr     <= '0;
      r_entry_cnt  <= '0;
      r_has_looped <= 1'b0;
      r_drop_cnt   <= '0;
    end else begin
      if (w_store) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
        if (r_entry_cnt != FULL_CNT) r_entry_cnt <= r_entry_cnt + 1'b1;
        if (&r_wr_ptr) r_has_looped <= 1'b1;
      end
      if (w_drop && !(&r_drop_cnt)) r_drop_cnt <= r_drop_cnt + 1'b1;
    end
  end

  if (SEC_W > 0) begin : g_sec
    assign w_rd_entry = rd_req_addr[RA_W-1 -: MEM_DEPTH_LOG2];
    assign w_rd_sec   = rd_req_addr[SEC_W-1:0];
  end else begin : g_nosec
    assign w_rd_entry = rd_req_addr;
    assign w_rd_sec   = '0;
  end

  ram_1r1w_sync_backpressure #(
    .DATA_W (MEM_W),
    .ADDR_W (MEM_DEPTH_LOG2)
  ) u_ram (
    .clk            (clk),
    .rst            (rst),
    .i_wr_en        (w_store),
    .i_wr_addr      (r_wr_ptr),
    .i_wr_data      (w_entry),
    .i_rd_req_val   (rd_req_val),
    .o_rd_req_rdy   (w_rd_req_rdy),
    .i_rd_addr      (w_rd_entry),
    .o_rd_resp_val  (w_ram_vld_p1),
    .i_rd_resp_rdy  (1'b1),
    .o_rd_resp_data (w_ram_data_p1)
  );

  assign w_rd_fire = rd_req_val & w_rd_req_rdy;

  // ---- stage p0 -> p1: section index follows the RAM access ----
  always_ff @(posedge clk) begin
    if (w_rd_fire) r_sec_p1 <= w_rd_sec;
  end

  always_comb begin
    w_sec_data = '0;
    for (int s = 0; s < NSEC; s++) begin
      if (SECI_W'(s) == r_sec_p1) w_sec_data = w_ram_data_p1[(NSEC-1-s)*OUTPUT_W +: OUTPUT_W];
    end
  end

  // ---- stage p1 -> p2: section select registered to the output ----
  always_ff @(posedge clk) begin
    if (rst) begin
      r_resp_vld_p2  <= 1'b0;
      r_resp_data_p2 <= '0;
    end else begin
      r_resp_vld_p2 <= w_ram_vld_p1;
      if (w_ram_vld_p1) r_resp_data_p2 <= w_sec_data;
    end
  end

  assign in_rdy       = w_grant;
  assign rd_resp_val  = r_resp_vld_p2;
  assign rd_resp_data = r_resp_data_p2;
  assign wr_ptr       = r_wr_ptr;
  assign entry_cnt    = r_entry_cnt;
  assign full         = w_full;
  assign has_looped   = r_has_looped;
  assign drop_cnt     = r_drop_cnt;

endmodule

// File: tb/tb_multi_chan_logger.sv
// Bench for multi_chan_logger (default parameters: 4 channels, 96-bit data,
// 28-bit timestamp, 256 entries, 64-bit readback, 128-bit stored words).
// A reference model tracks the stored log as an array plus beat/drop totals;
// read expectations go into a queue consumed by a monitor on rd_resp_val.
`timescale 1ns/1ps
module tb_multi_chan_logger;

  localparam int DEPTH = 256;

  logic         clk = 1'b0;
  logic         rst;
  logic         clear;
  logic         logging_active;
  logic         wrap_mode;
  logic [3:0]   in_val;
  logic [383:0] in_data;
  logic [3:0]   in_rdy;
  logic         rd_req_val;
  logic [8:0]   rd_req_addr;
  logic         rd_resp_val;
  logic [63:0]  rd_resp_data;
  logic [7:0]   wr_ptr;
  logic [8:0]   entry_cnt;
  logic         full;
  logic         has_looped;
  logic [15:0]  drop_cnt;

  multi_chan_logger #(
    .NUM_CHAN(4), .INPUT_W(96), .TS_W(28), .MEM_DEPTH_LOG2(8), .OUTPUT_W(64)
  ) dut (
    .clk(clk), .rst(rst), .clear(clear), .logging_active(logging_active),
    .wrap_mode(wrap_mode), .in_val(in_val), .in_data(in_data), .in_rdy(in_rdy),
    .rd_req_val(rd_req_val), .rd_req_addr(rd_req_addr), .rd_resp_val(rd_resp_val),
    .rd_resp_data(rd_resp_data), .wr_ptr(wr_ptr), .entry_cnt(entry_cnt),
    .full(full), .has_looped(has_looped), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [127:0] m_mem [DEPTH];
  bit           m_valid [DEPTH];
  int           m_stored;   // beats stored since last clear/reset
  int           m_drop;     // beats dropped since last clear/reset
  int           m_prio;     // channel with highest priority next
  int           m_cyc = 0;
  logic [27:0]  m_ts = 28'd0;

  typedef struct {
    logic [63:0] data;
    int          cyc;
  } rd_exp_t;
  rd_exp_t exp_q[$];

  int n_tests = 0;
  int n_fail  = 0;

  always @(posedge clk) begin
    m_cyc <= m_cyc + 1;
    m_ts  <= rst ? 28'd0 : m_ts + 28'd1;
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_status();
    int ec;
    int ed;
    ec = (m_stored > DEPTH) ? DEPTH : m_stored;
    ed = (m_drop > 65535) ? 65535 : m_drop;
    chk("wr_ptr",     128'(wr_ptr),     128'(m_stored % DEPTH));
    chk("entry_cnt",  128'(entry_cnt),  128'(ec));
    chk("full",       128'(full),       128'(ec == DEPTH));
    chk("has_looped", 128'(has_looped), 128'(m_stored >= DEPTH));
    chk("drop_cnt",   128'(drop_cnt),   128'(ed));
  endtask

  // Drive one cycle (entered just after a rising edge), update the model,
  // advance past the next edge and check status.
  task automatic step(input logic [3:0] v, input logic rd, input logic [8:0] ra);
    int          g;
    int          idx;
    logic [3:0]  er;
    logic [127:0] ent;
    in_val = v;
    for (int ch = 0; ch < 4; ch++) in_data[ch*96 +: 96] = {$urandom(), $urandom(), $urandom()};
    rd_req_val  = rd;
    rd_req_addr = ra;
    #1;
    g = -1;
    if (!rst) begin
      for (int k = 0; k < 4; k++) begin
        idx = (m_prio + k) % 4;
        if (g < 0 && v[idx]) g = idx;
      end
    end
    er = (g >= 0) ? 4'(1 << g) : 4'd0;
    chk("in_rdy", 128'(in_rdy), 128'(er));
    // Reads see the contents before this cycle's write.
    if (rd && !rst) begin
      ent = m_mem[ra[8:1]];
      exp_q.push_back('{data: (ra[0] ? ent[63:0] : ent[127:64]), cyc: m_cyc + 2});
    end
    if (rst) begin
      m_prio = 0; m_stored = 0; m_drop = 0;
      while (exp_q.size() > 0 && exp_q[$].cyc > m_cyc) void'(exp_q.pop_back());
    end else begin
      if (g >= 0) m_prio = (g + 1) % 4;
      if (clear) begin
        m_stored = 0; m_drop = 0;
      end else if (g >= 0 && logging_active) begin
        if (!wrap_mode && m_stored >= DEPTH) begin
          m_drop++;
        end else begin
          m_mem[m_stored % DEPTH]   = {m_ts, 2'(g), in_data[g*96 +: 96], 2'b00};
          m_valid[m_stored % DEPTH] = 1'b1;
          m_stored++;
        end
      end
    end
    @(posedge clk);
    #1;
    check_status();
  endtask

  logic [3:0] v;
  logic       rd;
  logic [8:0] ra;
  int         idx;

  initial begin
    fork
      forever begin
        rd_exp_t e;
        @(negedge clk);
        if (rd_resp_val === 1'b1) begin
          if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL rd_unexpected: got response %0h, expected none", rd_resp_data);
          end else begin
            e = exp_q.pop_front();
            chk("rd_data",    128'(rd_resp_data), 128'(e.data));
            chk("rd_latency", 128'(m_cyc),        128'(e.cyc));
          end
        end
      end
    join_none

    rst = 1'b1; clear = 1'b0; logging_active = 1'b0; wrap_mode = 1'b0;
    in_val = 4'h0; in_data = '0; rd_req_val = 1'b0; rd_req_addr = 9'd0;
    m_stored = 0; m_drop = 0; m_prio = 0;
    for (int i = 0; i < DEPTH; i++) m_valid[i] = 1'b0;
    @(posedge clk);
    #1;

    // Reset with all channels requesting: no grants, outputs at reset values
    repeat (2) step(4'hF, 1'b0, 9'd0);
    chk("rst_resp_val",  128'(rd_resp_val),  128'(0));
    chk("rst_resp_data", 128'(rd_resp_data), 128'(0));
    rst = 1'b0;
    logging_active = 1'b1;

    // All channels continuously valid: grants rotate 0,1,2,3,...
    for (int i = 0; i < 8; i++) step(4'hF, 1'b0, 9'd0);
    for (int i = 0; i < 8; i++) begin
      chk("rr_chan_id", 128'(m_mem[i][99:98]), 128'(i % 4));
      step(4'h0, 1'b1, {8'(i), 1'b0});
    end
    // Back-to-back sections of entry 5
    step(4'h0, 1'b1, {8'd5, 1'b0});
    step(4'h0, 1'b1, {8'd5, 1'b1});
    repeat (3) step(4'h0, 1'b0, 9'd0);

    // Random traffic, occasional sink cycles, random reads of written entries
    for (int i = 0; i < 150; i++) begin
      v  = 4'($urandom());
      rd = 1'b0;
      ra = 9'd0;
      logging_active = ($urandom_range(0, 7) != 0);
      idx = $urandom_range(0, 63);
      if ($urandom_range(0, 1) == 1 && m_valid[idx]) begin
        rd = 1'b1;
        ra = {8'(idx), 1'($urandom())};
      end
      step(v, rd, ra);
    end
    logging_active = 1'b1;

    // Stop-when-full: 260 beats
    clear = 1'b1; step(4'h0, 1'b0, 9'd0); clear = 1'b0;
    wrap_mode = 1'b0;
    for (int i = 0; i < 260; i++) step(4'(1 << $urandom_range(0, 3)), 1'b0, 9'd0);
    chk("nowrap_full",   128'(full),       128'(1));
    chk("nowrap_drop",   128'(drop_cnt),   128'(4));
    chk("nowrap_wrptr",  128'(wr_ptr),     128'(0));
    chk("nowrap_looped", 128'(has_looped), 128'(1));

    // Clear together with a transfer while full: discarded, not a drop
    clear = 1'b1; step(4'hF, 1'b0, 9'd0); clear = 1'b0;
    chk("clr_wrptr", 128'(wr_ptr),    128'(0));
    chk("clr_cnt",   128'(entry_cnt), 128'(0));
    chk("clr_drop",  128'(drop_cnt),  128'(0));
    step(4'h0, 1'b1, {8'd0, 1'b0});
    step(4'h0, 1'b1, {8'd0, 1'b1});

    // Read in flight across a clear, then circular mode with 300 beats
    step(4'h0, 1'b1, {8'd3, 1'b1});
    clear = 1'b1; step(4'h0, 1'b0, 9'd0); clear = 1'b0;
    wrap_mode = 1'b1;
    for (int i = 0; i < 300; i++) begin
      v  = 4'(1 << $urandom_range(0, 3));
      rd = 1'b0;
      ra = 9'd0;
      if (i >= 256 && (i % 5) == 0) begin
        rd = 1'b1;
        ra = {8'(m_stored % DEPTH), 1'($urandom())};
      end
      step(v, rd, ra);
    end
    chk("wrap_cnt",   128'(entry_cnt), 128'(256));
    chk("wrap_drop",  128'(drop_cnt),  128'(0));
    chk("wrap_wrptr", 128'(wr_ptr),    128'(44));
    step(4'h0, 1'b1, {8'd0, 1'b0});
    step(4'h0, 1'b1, {8'd0, 1'b1});
    repeat (3) step(4'h0, 1'b0, 9'd0);

    // Reset one cycle after a read: the response never appears
    step(4'h0, 1'b1, {8'd0, 1'b0});
    rst = 1'b1;
    step(4'hF, 1'b0, 9'd0);
    chk("rst_kill_val", 128'(rd_resp_val), 128'(0));
    step(4'hF, 1'b0, 9'd0);
    chk("rst_data", 128'(rd_resp_data), 128'(0));
    rst = 1'b0;
    repeat (4) step(4'h0, 1'b0, 9'd0);

    chk("rd_outstanding", 128'(exp_q.size()), 128'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
